// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data-memory bus.
// Stores to TXDATA queue bytes in a FIFO. Each byte is sent on tx as a start bit,
// eight data bits LSB first and one stop bit. Loads from STATUS report the FIFO state.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   A     in   [31:0] byte address
//   WE    in   store strobe
//   WD    in   [31:0] store data
//   RD    out  [31:0] load data, combinational, zero when sel=0
//   sel   out  address falls inside the 16-byte register window
//   tx    out  serial line, idle high, registered
//   busy  out  shifter active or FIFO not empty
//
// Register map (A[1:0] ignored):
//   0x0 TXDATA  W: push WD[7:0]          R: 0
//   0x4 STATUS  R: {count[3:0], ovf, busy, empty, full}  W: WD[3]=1 clears ovf
//   0x8, 0xC    reserved: read 0, writes ignored
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BcntW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus decode
  logic wr_txdata;
  logic wr_status;

  assign sel       = (A[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = WE & sel & (A[3:2] == 2'd0);
  assign wr_status = WE & sel & (A[3:2] == 2'd1);

  // FIFO state
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_ok;
  logic            push_drop;

  // Shifter state
  state_e           state_q, state_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_done;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // The shifter takes the head whenever it sits in IDLE with data waiting.
  assign pop = (state_q == StIdle) & ~empty;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = wr_txdata & (~full | pop);
  assign push_drop = wr_txdata & ~push_ok;

  // Storage needs no reset; emptiness is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= WD[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (push_drop) begin
        ovf_q <= 1'b1;
      end else if (wr_status && WD[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Shifter: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign bit_done = (bcnt_q == BcntW'(CLKS_PER_BIT - 1));

  // Shifter: next state
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StStart;
          bcnt_d  = '0;
          shreg_d = mem[rptr_q];
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          bcnt_d  = '0;
          bidx_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BcntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BcntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          state_d = StIdle;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BcntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifter: outputs. tx is registered from the next-state line level, so the line
  // changes on the same edge the state does and never sees WE or A combinationally.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[bidx_d];
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != StIdle) | ~empty;
  end

  assign tx = tx_q;

  // Load path: zero latency so a load can complete in the same cycle.
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic [31:0] status;

  assign count_ext = 32'(count_q);
  assign count_sat = (count_ext > 32'd15) ? 4'd15 : count_ext[3:0];
  assign status    = {24'b0, count_sat, ovf_q, busy, empty, full};

  always_comb begin
    RD = '0;
    if (sel && (A[3:2] == 2'd1)) begin
      RD = status;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{A[1:0], WD[31:8], count_ext[31:4]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-and-frame-position model predicts tx, busy, sel and RD
// on every cycle, and directed sequences add hand-computed literal expectations.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 8;
  localparam int          CPB   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A   = BASE + 32'h4;
  logic        WE  = 1'b0;
  logic [31:0] WD  = '0;
  logic [31:0] RD;
  logic        sel;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .sel  (sel),
    .tx   (tx),
    .busy (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Queue of pending bytes plus the position inside the current frame (-1 = idle).
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  int         m_pos = -1;
  logic [7:0] m_cur = '0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit m_busy();
    return (m_pos >= 0) || (m_q.size() != 0);
  endfunction

  function automatic logic m_tx();
    int sym;
    if (m_pos < 0) return 1'b1;
    sym = m_pos / CPB;
    if (sym == 0) return 1'b0;
    if (sym == 9) return 1'b1;
    return m_cur[sym-1];
  endfunction

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    int c = (n > 15) ? 15 : n;
    return 32'(c * 16 + (m_ovf ? 8 : 0) + (m_busy() ? 4 : 0) + (n == 0 ? 2 : 0) +
               (n == DEPTH ? 1 : 0));
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (in_win(a) && reg_of(a) == 1) return m_status();
    return 32'h0;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_pos = -1;
      m_cur = '0;
    end else begin
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == 10 * CPB) m_pos = -1;
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end
      if (WE && in_win(A) && reg_of(A) == 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(WD[7:0]);
        else m_ovf = 1'b1;
      end
      if (WE && in_win(A) && reg_of(A) == 1 && WD[3]) m_ovf = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle comparison, away from both edges.
  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("tx", tx, m_tx());
      check("busy", busy, m_busy());
      check("sel", sel, in_win(A));
      check("rd", RD, m_rd(A));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    A  = addr;
    WE = 1'b1;
    WD = data;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    WE = 1'b0;
    WD = '0;
    A  = BASE + 32'h4;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && m_q.size() == 0 && m_pos < 0) done = 1'b1;
    end
    if (!done) check("wait_idle timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] t2_bytes [9] = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h7E};

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [9:0] cap;
    bit         found;

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    check("reset status", RD, 32'h2);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: single byte 0x41, line levels sampled mid-bit
    store(BASE, 32'h41);
    bus_idle();
    cap = '0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      #1;
      if (c % CPB == CPB / 2) cap[c/CPB] = tx;
    end
    check("t1 frame bits", 32'(cap), 32'h282);
    check("t1 busy in stop", busy, 1'b1);
    @(negedge clk);
    #1;
    check("t1 busy after stop", busy, 1'b0);
    check("t1 tx idle", tx, 1'b1);

    // 2: nine back-to-back stores while idle
    for (int i = 0; i < 9; i++) store(BASE, 32'(t2_bytes[i]));
    bus_idle();
    #1;
    check("t2 status peak", RD, 32'h85);
    wait_idle(12 * (10 * CPB + 1));
    check("t2 status drained", RD, 32'h2);

    // 3: overflow while the shifter is busy, then clear ovf
    store(BASE, 32'hF0);
    bus_idle();
    for (int i = 0; i < 8; i++) store(BASE, 32'hE0 + 32'(i));
    bus_idle();
    #1;
    check("t3 full", RD, 32'h85);
    store(BASE, 32'hE8);
    store(BASE, 32'hE9);
    bus_idle();
    #1;
    check("t3 ovf set", RD, 32'h8D);
    store(BASE + 32'h4, 32'h8);
    bus_idle();
    #1;
    check("t3 ovf cleared", RD, 32'h85);

    // 4: push into a full FIFO on the IDLE->START pop edge
    found = 1'b0;
    for (int i = 0; i < 12 * CPB && !found; i++) begin
      @(negedge clk);
      if (m_pos < 0) found = 1'b1;
    end
    if (!found) check("t4 idle slot timeout", 32'd0, 32'd1);
    #1;
    check("t4 full before pop", RD, 32'h85);
    #1;
    A  = BASE;
    WE = 1'b1;
    WD = 32'h77;
    bus_idle();
    #1;
    check("t4 push on pop", RD, 32'h85);
    check("t4 start bit", tx, 1'b0);
    wait_idle(12 * (10 * CPB + 1));
    check("t4 drained", RD, 32'h2);

    // 5: reset in the middle of a 0x55 data phase
    store(BASE, 32'h55);
    bus_idle();
    repeat (40) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5 tx on reset", tx, 1'b1);
    check("t5 status on reset", RD, 32'h2);
    check("t5 busy on reset", busy, 1'b0);
    store(BASE, 32'hAA);
    @(negedge clk);
    WE  = 1'b0;
    A   = BASE + 32'h4;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    check("t5 no resume status", RD, 32'h2);
    check("t5 no resume tx", tx, 1'b1);

    // 6: decode and reserved offsets
    store(BASE + 32'h8, 32'h12);
    bus_idle();
    #1;
    check("t6 reserved write ignored", RD, 32'h2);
    @(negedge clk);
    A = BASE + 32'h4;
    #1;
    check("t6 sel status", sel, 1'b1);
    check("t6 rd status", RD, 32'h2);
    @(negedge clk);
    A = BASE + 32'h5;
    #1;
    check("t6 rd low bits ignored", RD, 32'h2);
    @(negedge clk);
    A = BASE + 32'hC;
    #1;
    check("t6 sel reserved", sel, 1'b1);
    check("t6 rd reserved", RD, 32'h0);
    @(negedge clk);
    A = 32'h0000_0100;
    #1;
    check("t6 sel outside", sel, 1'b0);
    check("t6 rd outside", RD, 32'h0);
    @(negedge clk);
    A = BASE;
    #1;
    check("t6 rd txdata", RD, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
